// File: rtl/mag_result_fifo.sv
// mag_result_fifo: captures finished results from the vector-magnitude unit,
// converts Q33.16 to a saturated Q(OUT_INT).(OUT_FRAC) word, and queues them
// in a small FIFO behind a valid/ready handshake. Full-FIFO drops are counted.
// Build option: define MAG_ROUND_EN for round-half-up at the output LSB;
// without it the fractional part is truncated.
module mag_result_fifo #(
   parameter int unsigned OUT_INT  = 16,
   parameter int unsigned OUT_FRAC = 8,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [32:0]                  yint_i,
   input  logic [15:0]                  ydec_i,
   input  logic                         fl_i,
   input  logic                         m_ready_i,
   output logic                         m_valid_o,
   output logic [OUT_INT+OUT_FRAC-1:0]  m_data_o,
   output logic                         m_sat_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic [7:0]                   drop_cnt_o
);

   localparam int unsigned OW   = OUT_INT + OUT_FRAC;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned RAWW = 33 + OUT_FRAC;
   localparam int unsigned RW   = RAWW + 1;

   // Edge detect and stage register
   logic              r_fl_q;
   logic              r_stg_v;
   logic [OW-1:0]     r_stg_data;
   logic              r_stg_sat;

   // FIFO storage and bookkeeping
   logic [OW-1:0]     r_mem_data [DEPTH];
   logic              r_mem_sat  [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [7:0]        r_drop_cnt;

   logic              w_cap;
   logic [RAWW-1:0]   w_raw;
   logic              w_rnd_bit;
   logic [RW-1:0]     w_round;
   logic              w_sat;
   logic [OW-1:0]     w_conv;
   logic              w_valid;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_unused_ydec;

   assign w_cap         = fl_i & ~r_fl_q;
   assign w_raw         = {yint_i, ydec_i[15 -: OUT_FRAC]};
   assign w_unused_ydec = ^ydec_i;

`ifdef MAG_ROUND_EN
   // Rounding bit is the first ydec bit below the kept fraction, if any exists.
   generate
      if (OUT_FRAC < 16) begin : g_rnd
         assign w_rnd_bit = ydec_i[15-OUT_FRAC];
      end else begin : g_nornd
         assign w_rnd_bit = 1'b0;
      end
   endgenerate
`else
   assign w_rnd_bit = 1'b0;
`endif

   // One spare MSB keeps the rounding carry so it can trigger saturation.
   assign w_round = {1'b0, w_raw} + RW'(w_rnd_bit);
   assign w_sat   = |w_round[RW-1:OW];
   assign w_conv  = w_sat ? '1 : w_round[OW-1:0];

   // Handshake and FIFO control
   always_comb begin
      w_valid = (r_count != '0);
      w_full  = (r_count == (AW+1)'(DEPTH));
      w_pop   = w_valid & m_ready_i;
      w_push  = r_stg_v & (~w_full | w_pop);
      w_drop  = r_stg_v & w_full & ~w_pop;
   end

   // Flag edge detect and conversion into the stage register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fl_q     <= 1'b1;
         r_stg_v    <= 1'b0;
         r_stg_data <= '0;
         r_stg_sat  <= 1'b0;
      end else begin
         r_fl_q  <= fl_i;
         r_stg_v <= w_cap;
         if (w_cap) begin
            r_stg_data <= w_conv;
            r_stg_sat  <= w_sat;
         end
      end
   end

   // FIFO storage; a push while full lands in the slot being popped this cycle
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= r_stg_data;
         r_mem_sat[r_wr_ptr]  <= r_stg_sat;
      end
   end

   // Pointers, occupancy and drop counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
         if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   // Head presentation; zero when empty
   always_comb begin
      m_valid_o  = w_valid;
      m_data_o   = w_valid ? r_mem_data[r_rd_ptr] : '0;
      m_sat_o    = w_valid ? r_mem_sat[r_rd_ptr]  : 1'b0;
      count_o    = r_count;
      drop_cnt_o = r_drop_cnt;
   end

endmodule

// File: tb/tb_mag_result_fifo.sv
// tb_mag_result_fifo: directed vectors for conversion plus hand sequences for
// full/drop, pop-during-full-push and reset with the flag held high.
module tb_mag_result_fifo;

   logic        clk;
   logic        rst;
   logic [32:0] yint;
   logic [15:0] ydec;
   logic        fl;
   logic        ready;
   logic        valid;
   logic [23:0] data;
   logic        sat;
   logic [2:0]  count;
   logic [7:0]  drop;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [32:0] yint;
      logic [15:0] ydec;
      logic [23:0] data;
      logic        sat;
   } vec_t;

   vec_t vecs[7];

   mag_result_fifo #(.OUT_INT(16), .OUT_FRAC(8), .DEPTH(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .yint_i     (yint),
      .ydec_i     (ydec),
      .fl_i       (fl),
      .m_ready_i  (ready),
      .m_valid_o  (valid),
      .m_data_o   (data),
      .m_sat_o    (sat),
      .count_o    (count),
      .drop_cnt_o (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Rising flag for one cycle then low for one cycle; stage pushes at second edge.
   task automatic cap(input logic [32:0] y);
      yint = y;
      ydec = 16'h0000;
      fl   = 1'b1;
      tick();
      fl   = 1'b0;
      tick();
   endtask

   task automatic set_vec(input int i, input logic [32:0] y, input logic [15:0] d,
                          input logic [23:0] ed, input logic es);
      vecs[i].yint = y;
      vecs[i].ydec = d;
      vecs[i].data = ed;
      vecs[i].sat  = es;
   endtask

   initial begin
      set_vec(0, 33'd5,     16'h8000, 24'h000580, 1'b0);
      set_vec(2, 33'd70000, 16'h0000, 24'hFFFFFF, 1'b1);
      set_vec(4, 33'd0,     16'h0000, 24'h000000, 1'b0);
      set_vec(6, 33'h1FFFFFFFF, 16'h1234, 24'hFFFFFF, 1'b1);
`ifdef MAG_ROUND_EN
      set_vec(1, 33'd5,     16'h0180, 24'h000502, 1'b0);
      set_vec(3, 33'd65535, 16'hFFFF, 24'hFFFFFF, 1'b1);
      set_vec(5, 33'd65535, 16'h00FF, 24'hFFFF01, 1'b0);
`else
      set_vec(1, 33'd5,     16'h0180, 24'h000501, 1'b0);
      set_vec(3, 33'd65535, 16'hFFFF, 24'hFFFFFF, 1'b0);
      set_vec(5, 33'd65535, 16'h00FF, 24'hFFFF00, 1'b0);
`endif

      rst = 1'b1; fl = 1'b0; ready = 1'b0; yint = '0; ydec = '0;
      tick();
      tick();
      chk("rst_valid", valid, 0);
      chk("rst_data",  data,  0);
      chk("rst_sat",   sat,   0);
      chk("rst_count", count, 0);
      chk("rst_drop",  drop,  0);
      rst = 1'b0;
      tick();

      // Conversion vectors: valid appears two edges after the rising flag.
      ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         yint = vecs[i].yint;
         ydec = vecs[i].ydec;
         fl   = 1'b1;
         tick();
         chk($sformatf("v%0d_valid_early", i), valid, 0);
         tick();
         chk($sformatf("v%0d_valid", i), valid, 1);
         chk($sformatf("v%0d_data", i),  data,  vecs[i].data);
         chk($sformatf("v%0d_sat", i),   sat,   vecs[i].sat);
         chk($sformatf("v%0d_count", i), count, 1);
         tick();
         chk($sformatf("v%0d_count_after", i), count, 0);
         chk($sformatf("v%0d_data_empty", i),  data,  0);
         fl = 1'b0;
         tick();
      end

      // Fill with consumer stalled: fifth result is dropped.
      ready = 1'b0;
      for (int k = 1; k <= 5; k++) cap(33'(k));
      tick();
      chk("full_count", count, 4);
      chk("full_drop",  drop,  1);
      chk("full_valid", valid, 1);
      ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("drain_%0d", k), data, 64'(k) << 8);
         tick();
      end
      chk("drain_count", count, 0);
      chk("drain_valid", valid, 0);

      // Push while full coinciding with a pop: accepted, no drop.
      ready = 1'b0;
      for (int k = 11; k <= 14; k++) cap(33'(k));
      chk("full2_count", count, 4);
      yint = 33'd15;
      fl   = 1'b1;
      tick();
      fl    = 1'b0;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("coinc_count", count, 4);
      chk("coinc_drop",  drop,  1);
      chk("coinc_head",  data,  24'h000C00);
      ready = 1'b1;
      for (int k = 12; k <= 15; k++) begin
         chk($sformatf("drain2_%0d", k), data, 64'(k) << 8);
         tick();
      end
      chk("drain2_count", count, 0);

      // Reset with two entries queued and the flag held high.
      ready = 1'b0;
      cap(33'd21);
      cap(33'd22);
      chk("pre_rst_count", count, 2);
      fl  = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_data",  data,  0);
      chk("mid_rst_sat",   sat,   0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_drop",  drop,  0);
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("post_rst_count", count, 0);
      chk("post_rst_valid", valid, 0);
      fl = 1'b0;
      tick();
      yint = 33'd23;
      fl   = 1'b1;
      tick();
      tick();
      chk("recap_valid", valid, 1);
      chk("recap_data",  data,  24'h001700);
      chk("recap_count", count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
